// File: rtl/pre_if_stage_pkg.sv
// Shared definitions for the pre-IF (PS) stage of the MIPS pipeline.
// Holds the bus widths, the AdEL exception code, the reset fetch address and
// the PS handshake FSM state encoding.
package pre_if_stage_pkg;

  localparam int unsigned PS_TO_FS_BUS_WD  = 39;
  localparam int unsigned BPU_TO_PS_BUS_WD = 33;

  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [31:0] RESET_PC_VAL = 32'hBFC0_0000;

  // RUN: normal flow; STALL: entry held, no transfer last cycle;
  // CANCEL: next transferred entry goes out as a bubble.
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StCancel = 2'd2
  } ps_state_e;

endpackage

// File: rtl/pre_if_stage_if.sv
// PS-stage bus interface: PS->FS handshake and bus, BPU redirect from FS,
// branch/exception flushes, and the ICache fetch request.
// master: the PS stage. slave: the surrounding pipeline and ICache.
interface pre_if_stage_if;
  import pre_if_stage_pkg::*;

  logic                        fs_allowin;
  logic                        ps_to_fs_valid;
  logic [PS_TO_FS_BUS_WD-1:0]  ps_to_fs_bus;
  logic [BPU_TO_PS_BUS_WD-1:0] BPU_to_ps_bus;
  logic                        br_flush;
  logic [31:0]                 br_target;
  logic                        flush;
  logic [31:0]                 ex_target;
  logic                        inst_req;
  logic [31:0]                 inst_addr;
  logic                        icache_busy;

  modport master (
    input  fs_allowin, BPU_to_ps_bus, br_flush, br_target, flush, ex_target, icache_busy,
    output ps_to_fs_valid, ps_to_fs_bus, inst_req, inst_addr
  );

  modport slave (
    output fs_allowin, BPU_to_ps_bus, br_flush, br_target, flush, ex_target, icache_busy,
    input  ps_to_fs_valid, ps_to_fs_bus, inst_req, inst_addr
  );

endinterface

// File: rtl/ps_redirect_arb.sv
// Next-PC priority mux for the PS stage plus the pending-prediction register.
// Priority: flush > br_flush > (xfer & prediction) > (xfer: pc+4) > hold.
// Ports:
//   clk/reset          core clock, async active-high reset
//   i_flush/i_ex_target exception/ERET redirect
//   i_br_flush/i_br_target mispredict redirect
//   i_xfer             PS entry moves to FS this cycle
//   i_predict_valid/i_predict_target BPU prediction from FS
//   i_ps_pc            current PS pc
//   o_next_pc          pc to load at the next clock edge
module ps_redirect_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic [31:0] i_ex_target,
  input  logic        i_br_flush,
  input  logic [31:0] i_br_target,
  input  logic        i_xfer,
  input  logic        i_predict_valid,
  input  logic [31:0] i_predict_target,
  input  logic [31:0] i_ps_pc,
  output logic [31:0] o_next_pc
);

  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic        w_pend_valid_d;
  logic [31:0] w_pend_target_d;

  always_comb begin
    o_next_pc       = i_ps_pc;
    w_pend_valid_d  = r_pend_valid;
    w_pend_target_d = r_pend_target;
    if (i_flush) begin
      o_next_pc       = i_ex_target;
      w_pend_valid_d  = 1'b0;
      w_pend_target_d = '0;
    end else if (i_br_flush) begin
      // A prediction arriving now belongs to a wrong-path FS entry.
      o_next_pc       = i_br_target;
      w_pend_valid_d  = 1'b0;
      w_pend_target_d = '0;
    end else if (i_xfer && (i_predict_valid || r_pend_valid)) begin
      // PS holds the delay slot; the target follows once it has transferred.
      o_next_pc       = i_predict_valid ? i_predict_target : r_pend_target;
      w_pend_valid_d  = 1'b0;
      w_pend_target_d = '0;
    end else if (i_xfer) begin
      o_next_pc = i_ps_pc + 32'd4;
    end else if (i_predict_valid) begin
      // Delay slot still stuck in PS: remember the target for later.
      w_pend_valid_d  = 1'b1;
      w_pend_target_d = i_predict_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_pend_valid  <= w_pend_valid_d;
      r_pend_target <= w_pend_target_d;
    end
  end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF (PS) stage: owns the fetch pc, issues ICache requests and drives the
// PS->FS valid/allowin handshake.
// Ports:
//   clk    core clock
//   reset  async active-high reset; all outputs read 0 while asserted
//   ps_if  master side of pre_if_stage_if (handshake, bus, redirects, ICache)
module pre_if_stage
  import pre_if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_VAL
) (
  input  logic           clk,
  input  logic           reset,
  pre_if_stage_if.master ps_if
);

  logic [31:0] r_ps_pc;
  logic        r_ps_valid;
  ps_state_e   r_state;
  ps_state_e   w_state_d;

  logic        w_ps_ex;
  logic        w_ready_go;
  logic        w_to_fs_valid;
  logic        w_xfer;
  logic        w_inst_valid;
  logic        w_predict_valid;
  logic [31:0] w_predict_target;
  logic [31:0] w_next_pc;

  assign w_predict_valid  = ps_if.BPU_to_ps_bus[0];
  assign w_predict_target = ps_if.BPU_to_ps_bus[32:1];

  assign w_ps_ex       = (r_ps_pc[1:0] != 2'b00);
  // A misaligned entry never goes to the ICache, so busy cannot hold it.
  assign w_ready_go    = w_ps_ex | ~ps_if.icache_busy;
  assign w_to_fs_valid = r_ps_valid & w_ready_go & ~ps_if.flush;
  assign w_xfer        = w_to_fs_valid & ps_if.fs_allowin;
  assign w_inst_valid  = ~(ps_if.br_flush | (r_state == StCancel));

  assign ps_if.ps_to_fs_valid = w_to_fs_valid;
  assign ps_if.inst_req       = r_ps_valid & ps_if.fs_allowin & ~w_ps_ex & ~ps_if.flush;
  assign ps_if.inst_addr      = reset ? 32'h0 : r_ps_pc;
  assign ps_if.ps_to_fs_bus   = reset ? '0 :
                                {w_inst_valid, r_ps_pc, w_ps_ex, (w_ps_ex ? EXC_ADEL : 5'h00)};

  ps_redirect_arb u_redirect_arb (
    .clk              (clk),
    .reset            (reset),
    .i_flush          (ps_if.flush),
    .i_ex_target      (ps_if.ex_target),
    .i_br_flush       (ps_if.br_flush),
    .i_br_target      (ps_if.br_target),
    .i_xfer           (w_xfer),
    .i_predict_valid  (w_predict_valid),
    .i_predict_target (w_predict_target),
    .i_ps_pc          (r_ps_pc),
    .o_next_pc        (w_next_pc)
  );

  always_comb begin
    w_state_d = r_state;
    if (ps_if.flush) begin
      w_state_d = StRun;
    end else if (ps_if.br_flush && !w_xfer) begin
      w_state_d = StCancel;
    end else begin
      unique case (r_state)
        StRun:    if (r_ps_valid && !w_xfer) w_state_d = StStall;
        StStall:  if (w_xfer) w_state_d = StRun;
        StCancel: if (w_xfer) w_state_d = StRun;
        default:  w_state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps_pc    <= RESET_PC;
      r_ps_valid <= 1'b0;
      r_state    <= StRun;
    end else begin
      r_ps_pc    <= w_next_pc;
      r_ps_valid <= 1'b1;
      r_state    <= w_state_d;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
module tb_pre_if_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pre_if_stage_if u_if ();

  pre_if_stage u_dut (
    .clk   (clk),
    .reset (reset),
    .ps_if (u_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", u_if.ps_to_fs_valid); end
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", u_if.inst_req); end
    checks++; if (u_if.inst_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_bus !== 39'h0) begin errors++; $display("FAIL rst_bus: got %h want 0", u_if.ps_to_fs_bus); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL rel_valid: got %b want 0", u_if.ps_to_fs_valid); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'hBFC0_0000 + 32'(4 * i);
      @(negedge clk); #1;
      checks++; if (u_if.inst_addr !== exp_pc) begin errors++; $display("FAIL seq_addr: got %h want %h", u_if.inst_addr, exp_pc); end
      checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL seq_valid: got %b want 1", u_if.ps_to_fs_valid); end
      checks++; if (u_if.ps_to_fs_bus[38] !== 1'b1) begin errors++; $display("FAIL seq_ivalid: got %b want 1", u_if.ps_to_fs_bus[38]); end
      checks++; if (u_if.inst_req !== 1'b1) begin errors++; $display("FAIL seq_req: got %b want 1", u_if.inst_req); end
    end
  endtask

  task automatic test_busy();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); u_if.icache_busy = 1'b1; #1;
      checks++; if (u_if.inst_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL busy_addr: got %h want bfc00010", u_if.inst_addr); end
      checks++; if (u_if.inst_req !== 1'b1) begin errors++; $display("FAIL busy_req: got %b want 1", u_if.inst_req); end
      checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL busy_valid: got %b want 0", u_if.ps_to_fs_valid); end
    end
    @(negedge clk); u_if.icache_busy = 1'b0; #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL unbusy_valid: got %b want 1", u_if.ps_to_fs_valid); end
    checks++; if (u_if.inst_addr !== 32'hBFC0_0010) begin errors++; $display("FAIL unbusy_addr: got %h want bfc00010", u_if.inst_addr); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0014) begin errors++; $display("FAIL busy_next: got %h want bfc00014", u_if.inst_addr); end
  endtask

  task automatic test_predict();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'hBFC0_0018 + 32'(4 * i);
      @(negedge clk); #1;
      checks++; if (u_if.inst_addr !== exp_pc) begin errors++; $display("FAIL pred_walk: got %h want %h", u_if.inst_addr, exp_pc); end
    end
    @(negedge clk); u_if.fs_allowin = 1'b0; u_if.BPU_to_ps_bus = {32'hBFC0_0100, 1'b1}; #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0024) begin errors++; $display("FAIL pred_slot: got %h want bfc00024", u_if.inst_addr); end
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL pred_req: got %b want 0", u_if.inst_req); end
    @(negedge clk); u_if.BPU_to_ps_bus = '0; #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0024) begin errors++; $display("FAIL pred_hold: got %h want bfc00024", u_if.inst_addr); end
    @(negedge clk); u_if.fs_allowin = 1'b1; #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0024) begin errors++; $display("FAIL pred_hold2: got %h want bfc00024", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL pred_xfer: got %b want 1", u_if.ps_to_fs_valid); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0100) begin errors++; $display("FAIL pred_target: got %h want bfc00100", u_if.inst_addr); end
  endtask

  task automatic test_br_flush();
    @(negedge clk); u_if.flush = 1'b1; u_if.ex_target = 32'hBFC0_0030; #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL fl_valid: got %b want 0", u_if.ps_to_fs_valid); end
    @(negedge clk); u_if.flush = 1'b0; u_if.br_flush = 1'b1; u_if.br_target = 32'h8000_0200; #1;
    checks++; if (u_if.ps_to_fs_bus[37:6] !== 32'hBFC0_0030) begin errors++; $display("FAIL br_pc: got %h want bfc00030", u_if.ps_to_fs_bus[37:6]); end
    checks++; if (u_if.ps_to_fs_bus[38] !== 1'b0) begin errors++; $display("FAIL br_ivalid: got %b want 0", u_if.ps_to_fs_bus[38]); end
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL br_valid: got %b want 1", u_if.ps_to_fs_valid); end
    @(negedge clk); u_if.br_flush = 1'b0; #1;
    checks++; if (u_if.inst_addr !== 32'h8000_0200) begin errors++; $display("FAIL br_next: got %h want 80000200", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_bus[38] !== 1'b1) begin errors++; $display("FAIL br_next_iv: got %b want 1", u_if.ps_to_fs_bus[38]); end
  endtask

  task automatic test_flush_combo();
    @(negedge clk); u_if.fs_allowin = 1'b0; u_if.BPU_to_ps_bus = {32'h8000_1000, 1'b1}; #1;
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL combo_req0: got %b want 0", u_if.inst_req); end
    @(negedge clk);
    u_if.fs_allowin = 1'b1; u_if.flush = 1'b1; u_if.ex_target = 32'hBFC0_0380;
    u_if.br_flush = 1'b1; u_if.br_target = 32'h8000_0400; u_if.BPU_to_ps_bus = {32'h8000_0800, 1'b1};
    #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL combo_valid: got %b want 0", u_if.ps_to_fs_valid); end
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL combo_req: got %b want 0", u_if.inst_req); end
    @(negedge clk); u_if.flush = 1'b0; u_if.br_flush = 1'b0; u_if.BPU_to_ps_bus = '0; #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0380) begin errors++; $display("FAIL combo_pc: got %h want bfc00380", u_if.inst_addr); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0384) begin errors++; $display("FAIL combo_pend: got %h want bfc00384", u_if.inst_addr); end
  endtask

  task automatic test_misaligned();
    @(negedge clk); u_if.flush = 1'b1; u_if.ex_target = 32'h8000_0002;
    @(negedge clk); u_if.flush = 1'b0; #1;
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", u_if.inst_req); end
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b want 1", u_if.ps_to_fs_valid); end
    checks++; if (u_if.ps_to_fs_bus[5] !== 1'b1) begin errors++; $display("FAIL mis_ex: got %b want 1", u_if.ps_to_fs_bus[5]); end
    checks++; if (u_if.ps_to_fs_bus[4:0] !== 5'h04) begin errors++; $display("FAIL mis_code: got %h want 04", u_if.ps_to_fs_bus[4:0]); end
    checks++; if (u_if.ps_to_fs_bus[37:6] !== 32'h8000_0002) begin errors++; $display("FAIL mis_pc: got %h want 80000002", u_if.ps_to_fs_bus[37:6]); end
    checks++; if (u_if.ps_to_fs_bus[38] !== 1'b1) begin errors++; $display("FAIL mis_iv: got %b want 1", u_if.ps_to_fs_bus[38]); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'h8000_0006) begin errors++; $display("FAIL mis_next: got %h want 80000006", u_if.inst_addr); end
  endtask

  task automatic test_cancel();
    @(negedge clk); u_if.flush = 1'b1; u_if.ex_target = 32'h8000_0010;
    @(negedge clk);
    u_if.flush = 1'b0; u_if.icache_busy = 1'b1; u_if.br_flush = 1'b1; u_if.br_target = 32'h8000_0020;
    #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL can_valid0: got %b want 0", u_if.ps_to_fs_valid); end
    @(negedge clk); u_if.icache_busy = 1'b0; u_if.br_flush = 1'b0; #1;
    checks++; if (u_if.inst_addr !== 32'h8000_0020) begin errors++; $display("FAIL can_pc: got %h want 80000020", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_bus[38] !== 1'b0) begin errors++; $display("FAIL can_bubble: got %b want 0", u_if.ps_to_fs_bus[38]); end
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL can_valid: got %b want 1", u_if.ps_to_fs_valid); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'h8000_0024) begin errors++; $display("FAIL can_next: got %h want 80000024", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_bus[38] !== 1'b1) begin errors++; $display("FAIL can_iv: got %b want 1", u_if.ps_to_fs_bus[38]); end
  endtask

  task automatic test_wrap();
    @(negedge clk); u_if.flush = 1'b1; u_if.ex_target = 32'hFFFF_FFFC;
    @(negedge clk); u_if.flush = 1'b0; #1;
    checks++; if (u_if.inst_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h want fffffffc", u_if.inst_addr); end
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h want 00000000", u_if.inst_addr); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); u_if.icache_busy = 1'b1;
    @(negedge clk); #1;
    checks++; if (u_if.ps_to_fs_valid !== 1'b0) begin errors++; $display("FAIL mid_stall: got %b want 0", u_if.ps_to_fs_valid); end
    #2 reset = 1'b1; #1;
    checks++; if (u_if.inst_addr !== 32'h0) begin errors++; $display("FAIL mid_addr: got %h want 0", u_if.inst_addr); end
    checks++; if (u_if.inst_req !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", u_if.inst_req); end
    checks++; if (u_if.ps_to_fs_bus !== 39'h0) begin errors++; $display("FAIL mid_bus: got %h want 0", u_if.ps_to_fs_bus); end
    @(negedge clk); reset = 1'b0; u_if.icache_busy = 1'b0;
    @(negedge clk); #1;
    checks++; if (u_if.inst_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL mid_pc: got %h want bfc00000", u_if.inst_addr); end
    checks++; if (u_if.ps_to_fs_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b want 1", u_if.ps_to_fs_valid); end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    reset              = 1'b1;
    u_if.fs_allowin    = 1'b1;
    u_if.icache_busy   = 1'b0;
    u_if.BPU_to_ps_bus = '0;
    u_if.br_flush      = 1'b0;
    u_if.br_target     = '0;
    u_if.flush         = 1'b0;
    u_if.ex_target     = '0;

    test_reset();
    test_sequential();
    test_busy();
    test_predict();
    test_br_flush();
    test_flush_combo();
    test_misaligned();
    test_cancel();
    test_wrap();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
